// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, NZCV flag bit positions and the
// decoder flag-write request encodings.
package cpu_pkg;

    // Width of the architectural {N,Z,C,V} flag vector and of the cond field.
    localparam int unsigned NZCV_W = 4;
    localparam int unsigned COND_W = 4;

    // Bit positions inside the {N,Z,C,V} vector.
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Decoder flag-write request bits.
    localparam logic [1:0] FLAGW_NZ = 2'b10;
    localparam logic [1:0] FLAGW_CV = 2'b01;

    // Instruction condition field, Instr[31:28].
    typedef enum logic [COND_W-1:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

endpackage : cpu_pkg

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether an instruction with the
// given cond field executes against the current {N,Z,C,V} flags.
//   cond  : instruction condition field
//   flags : registered {N,Z,C,V}
//   pass  : 1 when the condition holds
module cond_check
    import cpu_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [NZCV_W-1:0] flags,
    output logic              pass
);

    logic n_f;
    logic z_f;
    logic c_f;
    logic v_f;

    assign n_f = flags[FLAG_N];
    assign z_f = flags[FLAG_Z];
    assign c_f = flags[FLAG_C];
    assign v_f = flags[FLAG_V];

    // Condition decode.
    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z_f;
            COND_NE: pass = ~z_f;
            COND_CS: pass = c_f;
            COND_CC: pass = ~c_f;
            COND_MI: pass = n_f;
            COND_PL: pass = ~n_f;
            COND_VS: pass = v_f;
            COND_VC: pass = ~v_f;
            COND_HI: pass = c_f & ~z_f;
            COND_LS: pass = ~c_f | z_f;
            COND_GE: pass = ~(n_f ^ v_f);
            COND_LT: pass = n_f ^ v_f;
            COND_GT: pass = ~z_f & ~(n_f ^ v_f);
            COND_LE: pass = z_f | (n_f ^ v_f);
            COND_AL: pass = 1'b1;
            // 1111 is treated as unconditional in this ISA subset.
            COND_NV: pass = 1'b1;
            default: pass = 1'b1;
        endcase
    end

endmodule : cond_check

// File: rtl/cond_unit.sv
// Conditional-execution unit. Holds the NZCV flag register, evaluates the
// instruction condition against it and gates the decoder's side-effect
// requests so only executed instructions write state. Also keeps saturating
// executed/skipped instruction counters for debug.
//   clk, rst               : clock, synchronous active-high reset
//   en                     : instruction valid (0 = stall/bubble)
//   cond                   : Instr[31:28]
//   alu_flags              : {N,Z,C,V} produced by the current instruction
//   flag_w, pcs, reg_w, mem_w : raw decoder requests
//   pc_src, reg_write, mem_write : gated requests (combinational)
//   cond_ex                : instruction executes this cycle (combinational)
//   flags                  : registered {N,Z,C,V}
//   exec_cnt, skip_cnt     : saturating instruction counters
module cond_unit
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [COND_W-1:0] cond,
    input  logic [NZCV_W-1:0] alu_flags,
    input  logic [1:0]        flag_w,
    input  logic              pcs,
    input  logic              reg_w,
    input  logic              mem_w,
    output logic              pc_src,
    output logic              reg_write,
    output logic              mem_write,
    output logic              cond_ex,
    output logic [NZCV_W-1:0] flags,
    output logic [CNT_W-1:0]  exec_cnt,
    output logic [CNT_W-1:0]  skip_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NZCV_W-1:0] flags_q;
    logic [NZCV_W-1:0] flags_d;
    logic [CNT_W-1:0]  exec_q;
    logic [CNT_W-1:0]  exec_d;
    logic [CNT_W-1:0]  skip_q;
    logic [CNT_W-1:0]  skip_d;
    logic              pass;
    logic              wr_nz;
    logic              wr_cv;

    // Condition is evaluated against the pre-instruction flags (no bypass).
    cond_check u_cond_check (
        .cond  (cond),
        .flags (flags_q),
        .pass  (pass)
    );

    // Side-effect gating; reset and stall both suppress execution.
    assign cond_ex   = en & pass & ~rst;
    assign pc_src    = pcs   & cond_ex;
    assign reg_write = reg_w & cond_ex;
    assign mem_write = mem_w & cond_ex;

    assign wr_nz = cond_ex & (|(flag_w & FLAGW_NZ));
    assign wr_cv = cond_ex & (|(flag_w & FLAGW_CV));

    // Next-state for flags and counters.
    always_comb begin
        flags_d = flags_q;
        exec_d  = exec_q;
        skip_d  = skip_q;

        if (wr_nz) begin
            flags_d[FLAG_N] = alu_flags[FLAG_N];
            flags_d[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (wr_cv) begin
            flags_d[FLAG_C] = alu_flags[FLAG_C];
            flags_d[FLAG_V] = alu_flags[FLAG_V];
        end

        // Counters saturate rather than wrap.
        if (en) begin
            if (cond_ex) begin
                if (exec_q != CNT_MAX) begin
                    exec_d = exec_q + CNT_W'(1);
                end
            end else begin
                if (skip_q != CNT_MAX) begin
                    skip_d = skip_q + CNT_W'(1);
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
            exec_q  <= '0;
            skip_q  <= '0;
        end else begin
            flags_q <= flags_d;
            exec_q  <= exec_d;
            skip_q  <= skip_d;
        end
    end

    assign flags    = flags_q;
    assign exec_cnt = exec_q;
    assign skip_cnt = skip_q;

endmodule : cond_unit
